// File: rtl/game_pkg.sv
// Shared widths and state encoding for the paddle-game sequencer.
package game_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned SERVE_CNT_W = 6;
    localparam int unsigned HOLD_W      = 5;
    localparam int unsigned HOLD_FAST   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Event/button inputs and display/score outputs of the game sequencer.
interface game_ctrl_if;

    logic                             frame_tick;
    logic                             btn_left;
    logic                             btn_right;
    logic                             btn_pause;
    logic                             miss;
    logic                             brick_hit;
    logic [game_pkg::STATE_W-1:0]     state;
    logic [game_pkg::COORD_W-1:0]     paddle_x;
    logic                             ball_step;
    logic                             serve;
    logic [game_pkg::BCD_W-1:0]       score_d3;
    logic [game_pkg::BCD_W-1:0]       score_d2;
    logic [game_pkg::BCD_W-1:0]       score_d1;
    logic [game_pkg::BCD_W-1:0]       score_d0;
    logic [game_pkg::LIVES_W-1:0]     lives;
    logic                             game_over;

    modport master (
        output frame_tick, btn_left, btn_right, btn_pause, miss, brick_hit,
        input  state, paddle_x, ball_step, serve,
        input  score_d3, score_d2, score_d1, score_d0, lives, game_over
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_pause, miss, brick_hit,
        output state, paddle_x, ball_step, serve,
        output score_d3, score_d2, score_d1, score_d0, lives, game_over
    );

endinterface

// File: rtl/game_ctrl_bcd_score4.sv
// Four-digit BCD score register: clear, increment with carry, saturate at 9999.
module bcd_score4
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] d3,
    output logic [BCD_W-1:0] d2,
    output logic [BCD_W-1:0] d1,
    output logic [BCD_W-1:0] d0
);

    localparam logic [BCD_W-1:0] DIGIT_MAX  = BCD_W'(9);
    localparam logic [BCD_W-1:0] DIGIT_ZERO = BCD_W'(0);
    localparam logic [BCD_W-1:0] DIGIT_ONE  = BCD_W'(1);

    logic [BCD_W-1:0] r_d3, r_d2, r_d1, r_d0;
    logic             w_sat;

    assign w_sat = (r_d3 == DIGIT_MAX) && (r_d2 == DIGIT_MAX) &&
                   (r_d1 == DIGIT_MAX) && (r_d0 == DIGIT_MAX);

    // Ripple carry through the digits; a full counter simply stops.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_d3 <= DIGIT_ZERO;
            r_d2 <= DIGIT_ZERO;
            r_d1 <= DIGIT_ZERO;
            r_d0 <= DIGIT_ZERO;
        end else if (inc && !w_sat) begin
            if (r_d0 != DIGIT_MAX) begin
                r_d0 <= r_d0 + DIGIT_ONE;
            end else begin
                r_d0 <= DIGIT_ZERO;
                if (r_d1 != DIGIT_MAX) begin
                    r_d1 <= r_d1 + DIGIT_ONE;
                end else begin
                    r_d1 <= DIGIT_ZERO;
                    if (r_d2 != DIGIT_MAX) begin
                        r_d2 <= r_d2 + DIGIT_ONE;
                    end else begin
                        r_d2 <= DIGIT_ZERO;
                        r_d3 <= r_d3 + DIGIT_ONE;
                    end
                end
            end
        end
    end

    assign d3 = r_d3;
    assign d2 = r_d2;
    assign d1 = r_d1;
    assign d0 = r_d0;

endmodule

// File: rtl/game_ctrl.sv
// Paddle-game sequencer: state machine, paddle position, lives and BCD score.
// Define PADDLE_ACCEL_EN to double the paddle step after a long single-direction hold.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned PADDLE_W     = 64,
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  bus
);

    localparam int unsigned CALC_W    = COORD_W + 1;
    localparam int unsigned PADDLE_X0 = (SCREEN_W - PADDLE_W) / 2;

    localparam logic [CALC_W-1:0]      X_MAX_C     = CALC_W'(SCREEN_W - PADDLE_W);
    localparam logic [COORD_W-1:0]     X0_C        = COORD_W'(PADDLE_X0);
    localparam logic [LIVES_W-1:0]     LIVES_C     = LIVES_W'(LIVES_INIT);
    localparam logic [SERVE_CNT_W-1:0] SERVE_END_C = SERVE_CNT_W'(SERVE_FRAMES - 1);

    game_state_e              r_state;
    logic [COORD_W-1:0]       r_paddle_x;
    logic [LIVES_W-1:0]       r_lives;
    logic [SERVE_CNT_W-1:0]   r_serve_cnt;
    logic                     r_ball_step;
    logic                     r_serve;
    logic                     r_game_over;
    logic                     r_left_q, r_right_q, r_pause_q;

    logic                     w_left_rise, w_right_rise, w_pause_rise;
    logic                     w_active, w_move_en, w_start, w_score_inc;
    logic [CALC_W-1:0]        w_step, w_px, w_sum, w_dec, w_inc;
    logic [COORD_W-1:0]       w_paddle_nxt;

    assign w_left_rise  = bus.btn_left  && !r_left_q;
    assign w_right_rise = bus.btn_right && !r_right_q;
    assign w_pause_rise = bus.btn_pause && !r_pause_q;

    assign w_active    = (r_state == ST_SERVE) || (r_state == ST_PLAY);
    assign w_move_en   = w_active && bus.frame_tick;
    assign w_start     = (r_state == ST_IDLE) && (w_left_rise || w_right_rise);
    assign w_score_inc = (r_state == ST_PLAY) && bus.brick_hit;

`ifdef PADDLE_ACCEL_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold_dir;
    logic              w_one_dir;

    assign w_one_dir = bus.btn_left ^ bus.btn_right;

    // Count frames of an unbroken single-direction hold; r_hold_dir=1 means right.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_hold_dir <= 1'b0;
        end else if (!w_active || !w_one_dir) begin
            r_hold_cnt <= '0;
        end else if (bus.btn_right != r_hold_dir) begin
            r_hold_dir <= bus.btn_right;
            r_hold_cnt <= bus.frame_tick ? HOLD_W'(1) : HOLD_W'(0);
        end else if (bus.frame_tick && (r_hold_cnt < HOLD_W'(HOLD_FAST))) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    assign w_step = (r_hold_cnt >= HOLD_W'(HOLD_FAST)) ? CALC_W'(2 * PADDLE_STEP)
                                                       : CALC_W'(PADDLE_STEP);
`else
    assign w_step = CALC_W'(PADDLE_STEP);
`endif

    // Clamp in one extra bit so neither edge can wrap.
    always_comb begin
        w_px         = CALC_W'(r_paddle_x);
        w_sum        = w_px + w_step;
        w_dec        = (w_px > w_step) ? (w_px - w_step) : '0;
        w_inc        = (w_sum > X_MAX_C) ? X_MAX_C : w_sum;
        w_paddle_nxt = r_paddle_x;
        if (bus.btn_left && !bus.btn_right) begin
            w_paddle_nxt = w_dec[COORD_W-1:0];
        end else if (bus.btn_right && !bus.btn_left) begin
            w_paddle_nxt = w_inc[COORD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_paddle_x  <= X0_C;
            r_lives     <= LIVES_C;
            r_serve_cnt <= '0;
            r_ball_step <= 1'b0;
            r_serve     <= 1'b0;
            r_game_over <= 1'b0;
            r_left_q    <= 1'b1;
            r_right_q   <= 1'b1;
            r_pause_q   <= 1'b1;
        end else begin
            r_left_q    <= bus.btn_left;
            r_right_q   <= bus.btn_right;
            r_pause_q   <= bus.btn_pause;
            r_ball_step <= (r_state == ST_PLAY) && bus.frame_tick;
            if (w_move_en) begin
                r_paddle_x <= w_paddle_nxt;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_SERVE;
                        r_serve     <= 1'b1;
                        r_lives     <= LIVES_C;
                        r_paddle_x  <= X0_C;
                        r_serve_cnt <= '0;
                    end
                end
                ST_SERVE: begin
                    if (bus.frame_tick) begin
                        if (r_serve_cnt == SERVE_END_C) begin
                            r_state     <= ST_PLAY;
                            r_serve     <= 1'b0;
                            r_serve_cnt <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + SERVE_CNT_W'(1);
                        end
                    end
                end
                // A miss takes priority over a pause edge in the same cycle.
                ST_PLAY: begin
                    if (bus.miss) begin
                        if (r_lives > LIVES_W'(1)) begin
                            r_lives     <= r_lives - LIVES_W'(1);
                            r_state     <= ST_SERVE;
                            r_serve     <= 1'b1;
                            r_serve_cnt <= '0;
                        end else begin
                            r_lives     <= '0;
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end
                    end else if (w_pause_rise) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_rise) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (w_pause_rise) begin
                        r_state     <= ST_IDLE;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_serve     <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    bcd_score4 u_score (
        .clk (clk),
        .rst (rst),
        .clr (w_start),
        .inc (w_score_inc),
        .d3  (bus.score_d3),
        .d2  (bus.score_d2),
        .d1  (bus.score_d1),
        .d0  (bus.score_d0)
    );

    assign bus.state     = r_state;
    assign bus.paddle_x  = r_paddle_x;
    assign bus.ball_step = r_ball_step;
    assign bus.serve     = r_serve;
    assign bus.lives     = r_lives;
    assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a behavioural model queues expectations per cycle.
module tb_game_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_ctrl_if gif ();

    game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tot = 0;
    int   n_bad = 0;

    int m_st, m_px, m_score, m_lives, m_cnt, m_hc;
    bit m_bs, m_pl, m_pr, m_pp, m_hd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [31:0] dut_score();
        return 32'({gif.score_d3, gif.score_d2, gif.score_d1, gif.score_d0});
    endfunction

    // Behavioural model of one clock edge, using the currently driven inputs.
    task automatic model_step();
        bit lr, rr, pr, act, one;
        int step, nx;
        if (rst) begin
            m_st = 0; m_px = 288; m_score = 0; m_lives = 3; m_cnt = 0;
            m_bs = 0; m_pl = 1; m_pr = 1; m_pp = 1; m_hc = 0; m_hd = 0;
            return;
        end
        lr = gif.btn_left && !m_pl;
        rr = gif.btn_right && !m_pr;
        pr = gif.btn_pause && !m_pp;
        m_pl = gif.btn_left; m_pr = gif.btn_right; m_pp = gif.btn_pause;
        m_bs = (m_st == 2) && gif.frame_tick;
        act  = (m_st == 1) || (m_st == 2);
        one  = gif.btn_left ^ gif.btn_right;
        step = 4;
`ifdef PADDLE_ACCEL_EN
        if (m_hc >= 16) step = 8;
        if (!act || !one) m_hc = 0;
        else if (gif.btn_right != m_hd) begin m_hd = gif.btn_right; m_hc = gif.frame_tick ? 1 : 0; end
        else if (gif.frame_tick && m_hc < 16) m_hc++;
`endif
        if (act && gif.frame_tick && one) begin
            if (gif.btn_left) begin nx = m_px - step; m_px = (nx < 0) ? 0 : nx; end
            else begin nx = m_px + step; m_px = (nx > 576) ? 576 : nx; end
        end
        case (m_st)
            0: if (lr || rr) begin m_st = 1; m_score = 0; m_lives = 3; m_px = 288; m_cnt = 0; end
            1: if (gif.frame_tick) begin
                   if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end else m_cnt++;
               end
            2: begin
                   if (gif.brick_hit && m_score < 9999) m_score++;
                   if (gif.miss) begin
                       if (m_lives > 1) begin m_lives--; m_st = 1; m_cnt = 0; end
                       else begin m_lives = 0; m_st = 4; end
                   end else if (pr) m_st = 3;
               end
            3: if (pr) m_st = 2;
            4: if (pr) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0: check("state",     32'(gif.state),     e.exp);
                1: check("paddle_x",  32'(gif.paddle_x),  e.exp);
                2: check("score",     dut_score(),        e.exp);
                3: check("lives",     32'(gif.lives),     e.exp);
                4: check("serve",     32'(gif.serve),     e.exp);
                5: check("game_over", 32'(gif.game_over), e.exp);
                default: check("ball_step", 32'(gif.ball_step), e.exp);
            endcase
        end
    endtask

    task automatic cyc();
        model_step();
        sb_q.push_back('{0, 32'(m_st)});
        sb_q.push_back('{1, 32'(m_px)});
        sb_q.push_back('{2, 32'(to_bcd(m_score))});
        sb_q.push_back('{3, 32'(m_lives)});
        sb_q.push_back('{4, 32'(m_st == 1)});
        sb_q.push_back('{5, 32'(m_st == 4)});
        sb_q.push_back('{6, 32'(m_bs)});
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic frame();
        gif.frame_tick = 1'b1; cyc();
        gif.frame_tick = 1'b0; cyc();
    endtask

    task automatic press_pause();
        gif.btn_pause = 1'b1; cyc();
        gif.btn_pause = 1'b0; cyc();
    endtask

    task automatic pulse_miss();
        gif.miss = 1'b1; cyc();
        gif.miss = 1'b0; cyc();
    endtask

    task automatic bricks(input int n);
        gif.brick_hit = 1'b1;
        repeat (n) cyc();
        gif.brick_hit = 1'b0;
        cyc();
    endtask

    task automatic serve_out();
        repeat (60) frame();
        check("serve_to_play", 32'(gif.state), 32'd2);
    endtask

    initial begin
        rst = 1'b1;
        gif.frame_tick = 1'b0; gif.btn_left = 1'b1; gif.btn_right = 1'b0;
        gif.btn_pause  = 1'b0; gif.miss     = 1'b0; gif.brick_hit = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_state",  32'(gif.state),    32'd0);
        check("rst_paddle", 32'(gif.paddle_x), 32'd288);
        check("rst_lives",  32'(gif.lives),    32'd3);
        check("rst_score",  dut_score(),       32'h0000);

        // Left held through reset must not start a game.
        repeat (3) cyc();
        check("held_no_start", 32'(gif.state), 32'd0);
        gif.btn_left = 1'b0; cyc();
        gif.btn_left = 1'b1; cyc();
        check("start_serve", 32'(gif.state), 32'd1);
        gif.btn_left = 1'b0; cyc();

        serve_out();
        frame();

        gif.btn_left = 1'b1;
        repeat (80) frame();
        gif.btn_left = 1'b0;
        check("paddle_left_edge", 32'(gif.paddle_x), 32'd0);
        gif.btn_right = 1'b1;
        repeat (150) frame();
        check("paddle_right_edge", 32'(gif.paddle_x), 32'd576);
        gif.btn_left = 1'b1;
        repeat (5) frame();
        check("paddle_both_hold", 32'(gif.paddle_x), 32'd576);
        gif.btn_left = 1'b0; gif.btn_right = 1'b0; cyc();

        bricks(999);
        check("score_0999", dut_score(), 32'h0999);
        bricks(1);
        check("score_1000", dut_score(), 32'h1000);
        bricks(8999);
        check("score_9999", dut_score(), 32'h9999);
        bricks(1);
        check("score_sat", dut_score(), 32'h9999);

        pulse_miss();
        check("miss1_lives", 32'(gif.lives), 32'd2);
        check("miss1_state", 32'(gif.state), 32'd1);
        serve_out();
        pulse_miss();
        check("miss2_lives", 32'(gif.lives), 32'd1);
        serve_out();
        pulse_miss();
        check("miss3_lives", 32'(gif.lives),     32'd0);
        check("miss3_over",  32'(gif.game_over), 32'd1);
        press_pause();
        check("over_to_idle", 32'(gif.state), 32'd0);
        check("idle_keeps_score", dut_score(), 32'h9999);

        gif.btn_right = 1'b1; cyc();
        gif.btn_right = 1'b0; cyc();
        check("restart_score", dut_score(),       32'h0000);
        check("restart_lives", 32'(gif.lives),    32'd3);
        check("restart_px",    32'(gif.paddle_x), 32'd288);
        serve_out();

        // Paused: no motion, no ball step, events ignored.
        press_pause();
        check("paused", 32'(gif.state), 32'd3);
        gif.btn_left = 1'b1;
        repeat (3) frame();
        gif.btn_left = 1'b0;
        pulse_miss();
        bricks(2);
        check("pause_px_hold", 32'(gif.paddle_x), 32'd288);
        press_pause();
        check("unpaused", 32'(gif.state), 32'd2);

        bricks(41);
        pulse_miss();
        serve_out();
        check("pre_sim_score", dut_score(), 32'h0041);
        gif.miss = 1'b1; gif.brick_hit = 1'b1; gif.btn_pause = 1'b1; cyc();
        gif.miss = 1'b0; gif.brick_hit = 1'b0; gif.btn_pause = 1'b0;
        check("sim_score", dut_score(),    32'h0042);
        check("sim_lives", 32'(gif.lives), 32'd1);
        check("sim_state", 32'(gif.state), 32'd1);
        cyc();

        // Reset coinciding with a PLAY frame tick cancels the ball step.
        serve_out();
        gif.btn_right = 1'b1; repeat (3) frame(); gif.btn_right = 1'b0;
        gif.frame_tick = 1'b1; rst = 1'b1; cyc();
        gif.frame_tick = 1'b0; rst = 1'b0;
        check("rst_mid_step",  32'(gif.ball_step), 32'd0);
        check("rst_mid_state", 32'(gif.state),     32'd0);
        check("rst_mid_px",    32'(gif.paddle_x),  32'd288);
        cyc();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
